bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the bit-stream state machines in the StateMachine area. It accepts a WIDTH-bit word over a valid/ready handshake and emits the word one bit per bit period on `bit_out`. It sits directly upstream of the Moore sequence detectors (e.g. the 1101 detector), whose `input_bit` is driven from `bit_out`. With DIV=1 and back-to-back loads, the stream has no gaps, so a detector sees one new bit every clock.

## Interface
- `WIDTH`, 8: data word width; legal range ≥2.
- `DIV`, 1: clock cycles per serial bit; legal range ≥1.
- `MSB_FIRST`, 1: 1 = shift out the MSB first; 0 = shift out the LSB first.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  producer has a word on `load_data`.
- `load_data`  in  WIDTH  word to serialize; sampled only on an accept.
- `load_ready`  out  1  serializer can accept a word this cycle.
- `bit_out`  out  1  current serial bit; feeds the detector's `input_bit`.
- `bit_valid`  out  1  high while `bit_out` carries a data or parity bit.
- `last_bit`  out  1  high during the final cycle of the final bit of a word.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- **Accept:** a word is accepted on a rising edge where `load_valid && load_ready`. Only then is the word copied into the shift register; `load_data` is ignored at all other times.
- **FSM states:**
  - IDLE: nothing to send.
  - SHIFT: data bits in flight.
  - PARITY: parity bit in flight; exists only when the parity macro is defined.
- **Transitions:**
  - IDLE → SHIFT on accept.
  - SHIFT → SHIFT after each bit while bits remain.
  - After the last data bit: SHIFT → PARITY if parity is compiled in. Otherwise SHIFT → SHIFT if a new word is accepted, else SHIFT → IDLE.
  - PARITY → SHIFT on accept, else PARITY → IDLE.
- **Ready rule:** `load_ready` = IDLE OR `last_bit`. This allows gapless streaming.
- **Bit period:** the divider counts 0..DIV-1. The bit advances when the count wraps. With DIV=1 the bit advances every cycle.
- **Bit counter:** counts 0..WIDTH-1. It is reset to 0 on every accept.
- **Outputs in IDLE:** `bit_out`=0, `bit_valid`=0, `last_bit`=0.
- **Reset:** asynchronous assertion forces IDLE and clears the shift register, bit counter and divider from any state, mid-word included. The in-flight word is discarded and never resumed.
- **Simultaneous events:** `load_valid` while not ready is ignored; the producer must hold the word. An accept on `last_bit` loads the new word, and its first bit appears on the next cycle.

## Timing
- **Reset values:** `bit_out`=0, `bit_valid`=0, `last_bit`=0, `busy`=0, `load_ready`=1 (combinational from IDLE).
- **Latency:** if a word is accepted at edge k, its first bit is on `bit_out` from edge k+1. Each bit is held exactly DIV cycles.
- **Word duration:** WIDTH·DIV cycles, or (WIDTH+1)·DIV cycles with parity.
- **Registered outputs:** `bit_out` and `bit_valid` are registered, so there is no combinational path from the load inputs to them.
- **Stream continuity:** with continuous `load_valid`, `bit_valid` stays high with no idle cycle between words.

## Configuration
- Macro: `BIT_SERIALIZER_PARITY_EN`.
- **Defined:** an even-parity bit (XOR of all WIDTH data bits) is appended after the data as one extra bit period, with `bit_valid`=1. In this case `last_bit` marks the parity bit, not the last data bit.
- **Undefined:** the PARITY state and parity logic are absent, and `last_bit` marks the last data bit.

## Structure
- **Shared package `bit_serializer_pkg`:**
  - state encodings: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2;
  - helper constant for the counter width, $clog2(WIDTH);
  - helper constant for the divider width, $clog2(DIV)+1.
- **Sub-module `bit_rate_divider`:** DIV-cycle tick generator with a synchronous restart, restarted on every accept. Instantiate it once.

## Test plan
- **Basic MSB-first:** WIDTH=8, DIV=1, MSB_FIRST=1; load 8'hD0 → `bit_out` = 1,1,0,1,0,0,0,0 on cycles k+1..k+8; `last_bit` high on cycle k+8; a downstream 1101 detector asserts once.
- **Back-to-back:** hold `load_valid` with words 8'hFF then 8'h0D → 16 consecutive cycles with `bit_valid`=1; second word accepted on the first word's `last_bit` cycle; no gap.
- **Divider:** DIV=3; load 8'hA5 → each bit held 3 cycles; `last_bit` high only during cycle k+24; `busy` falls at edge k+25.
- **LSB-first:** MSB_FIRST=0; load 8'h0B → `bit_out` = 1,1,0,1,0,0,0,0.
- **Reset mid-word:** pull `rst_n` low after bit 3 of 8'hD0 → outputs go to reset values immediately; after release, `load_ready`=1 and a new load starts at bit 0.
- **Parity:** with `BIT_SERIALIZER_PARITY_EN`, load 8'h07 → 8 data bits then parity bit 1; `last_bit` on the ninth bit; without the macro the word is 8 bits.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared types and width helpers for the bit serializer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bit_serializer_pkg;

    // FSM encoding; PARITY is only entered when the parity bit is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    // Bit counter width: indexes 0..width-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    // Divider counter width: holds 0..div-1, never narrower than one bit.
    function automatic int div_width(input int div);
        return $clog2(div) + 1;
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Load handshake and serial-stream bundle between a word producer, the serializer and a bit consumer.
// Latency: n/a (wiring only).
// Backpressure: load_valid/load_ready; the serial side has no backpressure.
// Signals: load_valid/load_data/load_ready (word in), bit_out/bit_valid/last_bit (stream out), busy.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             last_bit;
    logic             busy;

    // Producer/consumer side.
    modport master (
        output load_valid, load_data,
        input  load_ready, bit_out, bit_valid, last_bit, busy
    );

    // Serializer side.
    modport slave (
        input  load_valid, load_data,
        output load_ready, bit_out, bit_valid, last_bit, busy
    );
endinterface

// File: rtl/bit_rate_divider.sv
// Bit-period tick generator: tick is high on the last cycle of every DIV-cycle period.
// Latency: after restart the first tick arrives DIV cycles later (same cycle when DIV=1).
// Backpressure: none; synchronous restart realigns the period to the next cycle.
// Ports: clk, rst_n, restart (in), tick (out).
module bit_rate_divider
    import bit_serializer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int              DIV_W = div_width(DIV);
    localparam logic [DIV_W-1:0] TOP  = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q;

    assign tick = (cnt_q == TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one WIDTH-bit word out as WIDTH bits (plus optional even parity bit).
// Latency: word accepted at an edge drives its first bit right after that edge; each bit lasts DIV cycles.
// Backpressure: load_ready only in IDLE or on last_bit, so back-to-back words stream without gaps.
// Ports: clk, rst_n, bus (slave: load_valid/load_data/load_ready, bit_out/bit_valid/last_bit/busy).
// Option: define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    bit_serializer_if.slave bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q;
    logic             tick;
    logic             accept;
    logic             last_data;
    logic             last_bit;
    logic             load_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    bit_rate_divider #(
        .DIV (DIV)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept),
        .tick    (tick)
    );

    // Final cycle of the final data bit.
    assign last_data = (state_q == SHIFT) && tick && (bit_cnt_q == LAST_IDX);

`ifdef BIT_SERIALIZER_PARITY_EN
    assign last_bit = (state_q == PARITY) && tick;
`else
    assign last_bit = last_data;
`endif

    // Accepting on last_bit reloads in the same edge that would end the word.
    assign load_ready = (state_q == IDLE) || last_bit;
    assign accept     = bus.load_valid && load_ready;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (last_data) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                if (tick) state_d = accept ? SHIFT : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Shift register / bit counter next values.
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d     = par_q;
`endif
        if (accept) begin
            sr_d      = bus.load_data;
            bit_cnt_d = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_d     = ^bus.load_data;
`endif
        end else if ((state_q == SHIFT) && tick) begin
            sr_d      = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
            bit_cnt_d = last_data ? '0 : bit_cnt_q + 1'b1;
        end
    end

    // The serial output is registered: decode what the line carries in the next state.
    always_comb begin
        bit_out_d = 1'b0;
        case (state_d)
            SHIFT:   bit_out_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY:  bit_out_d = par_d;
`endif
            default: bit_out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= (state_d != IDLE);
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.bit_out    = bit_out_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.last_bit   = last_bit;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances (MSB/DIV=1, MSB/DIV=3, LSB/DIV=1).
// Latency: first bit checked on the cycle right after the accepting edge.
// Backpressure: producer holds load_valid and watches load_ready like a real source.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int L = 9;
`else
    localparam int L = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       lv  [3];
    logic [7:0] ld  [3];
    logic       bo  [3];
    logic       bv  [3];
    logic       lb  [3];
    logic       rdy [3];
    logic       bsy [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(8)) if_a ();
    bit_serializer_if #(.WIDTH(8)) if_b ();
    bit_serializer_if #(.WIDTH(8)) if_c ();

    bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    bit_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    assign if_a.load_valid = lv[0];
    assign if_a.load_data  = ld[0];
    assign if_b.load_valid = lv[1];
    assign if_b.load_data  = ld[1];
    assign if_c.load_valid = lv[2];
    assign if_c.load_data  = ld[2];

    assign bo[0] = if_a.bit_out;  assign bv[0] = if_a.bit_valid; assign lb[0] = if_a.last_bit;
    assign rdy[0] = if_a.load_ready; assign bsy[0] = if_a.busy;
    assign bo[1] = if_b.bit_out;  assign bv[1] = if_b.bit_valid; assign lb[1] = if_b.last_bit;
    assign rdy[1] = if_b.load_ready; assign bsy[1] = if_b.busy;
    assign bo[2] = if_c.bit_out;  assign bv[2] = if_c.bit_valid; assign lb[2] = if_c.last_bit;
    assign rdy[2] = if_c.load_ready; assign bsy[2] = if_c.busy;

    // Downstream Moore 1101 detector on instance A's stream.
    logic [2:0] hist = 3'b000;
    int         det_cnt = 0;
    always @(negedge clk) begin
        if (bv[0]) begin
            if ({hist, bo[0]} == 4'b1101) det_cnt++;
            hist <= {hist[1:0], bo[0]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // seq[8] is the first bit on the line, seq[0] the parity bit (used only with parity).
    task automatic send_word(input int d, input logic [7:0] w, input logic [8:0] seq, input int div);
        @(negedge clk);
        chk("idle_ready", {31'd0, rdy[d]}, 32'd1);
        lv[d] = 1'b1;
        ld[d] = w;
        @(negedge clk);
        lv[d] = 1'b0;
        ld[d] = 8'h00;
        for (int b = 0; b < L; b++) begin
            for (int c = 0; c < div; c++) begin
                chk("bit",   {31'd0, bo[d]},  {31'd0, seq[8-b]});
                chk("valid", {31'd0, bv[d]},  32'd1);
                chk("busy",  {31'd0, bsy[d]}, 32'd1);
                chk("last",  {31'd0, lb[d]},  {31'd0, (b == L-1) && (c == div-1)});
                chk("ready", {31'd0, rdy[d]}, {31'd0, (b == L-1) && (c == div-1)});
                @(negedge clk);
            end
        end
        chk("end_valid", {31'd0, bv[d]},  32'd0);
        chk("end_busy",  {31'd0, bsy[d]}, 32'd0);
        chk("end_bit",   {31'd0, bo[d]},  32'd0);
        chk("end_last",  {31'd0, lb[d]},  32'd0);
        chk("end_ready", {31'd0, rdy[d]}, 32'd1);
    endtask

    initial begin
        logic [8:0] s1;
        logic [8:0] s2;
        int         det0;
        for (int i = 0; i < 3; i++) begin
            lv[i] = 1'b0;
            ld[i] = 8'h00;
        end

        // Reset values.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_bit",   {31'd0, bo[i]},  32'd0);
            chk("rst_valid", {31'd0, bv[i]},  32'd0);
            chk("rst_last",  {31'd0, lb[i]},  32'd0);
            chk("rst_busy",  {31'd0, bsy[i]}, 32'd0);
            chk("rst_ready", {31'd0, rdy[i]}, 32'd1);
        end
        #2 rst_n = 1'b1;

        // Basic MSB-first: D0 -> 1101 0000, parity 1.
        det0 = det_cnt;
        send_word(0, 8'hD0, 9'b1_1010_0001, 1);
        chk("det_1101", det_cnt - det0, 32'd1);

        // Divider DIV=3: A5 -> 1010 0101, parity 0.
        send_word(1, 8'hA5, 9'b1_0100_1010, 3);

        // LSB-first: 0B -> 1101 0000, parity 1.
        send_word(2, 8'h0B, 9'b1_1010_0001, 1);

        // Parity (or plain 8-bit word): 07 -> 0000 0111, parity 1.
        send_word(0, 8'h07, 9'b0_0000_1111, 1);

        // Back-to-back FF then 0D; garbage offered while not ready must be ignored.
        s1 = 9'b1_1111_1110;
        s2 = 9'b0_0001_1011;
        @(negedge clk);
        lv[0] = 1'b1;
        ld[0] = 8'hFF;
        @(negedge clk);
        ld[0] = 8'h55;
        for (int c = 0; c < 2*L; c++) begin
            chk("b2b_valid", {31'd0, bv[0]}, 32'd1);
            chk("b2b_bit",   {31'd0, bo[0]}, {31'd0, (c < L) ? s1[8-c] : s2[8-(c-L)]});
            chk("b2b_last",  {31'd0, lb[0]}, {31'd0, (c == L-1) || (c == 2*L-1)});
            chk("b2b_ready", {31'd0, rdy[0]}, {31'd0, (c == L-1) || (c == 2*L-1)});
            if (c == L-1) ld[0] = 8'h0D;
            if (c == L)   lv[0] = 1'b0;
            @(negedge clk);
        end
        chk("b2b_end_valid", {31'd0, bv[0]}, 32'd0);

        // Reset mid-word after bit 3 of D0.
        s1 = 9'b1_1010_0001;
        @(negedge clk);
        lv[0] = 1'b1;
        ld[0] = 8'hD0;
        @(negedge clk);
        lv[0] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("pre_rst_bit", {31'd0, bo[0]}, {31'd0, s1[8-b]});
            if (b < 3) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bit",   {31'd0, bo[0]},  32'd0);
        chk("mid_rst_valid", {31'd0, bv[0]},  32'd0);
        chk("mid_rst_last",  {31'd0, lb[0]},  32'd0);
        chk("mid_rst_busy",  {31'd0, bsy[0]}, 32'd0);
        chk("mid_rst_ready", {31'd0, rdy[0]}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send_word(0, 8'hD0, 9'b1_1010_0001, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
